// File: rtl/vec_pkg.sv
// Shared types and width helpers for the vector square-root unit.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqrt_state_e;

  localparam int VEC_WIDTH = 32;

  function automatic int root_width(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/vec_isqrt_step.sv
// One restoring square-root iteration: brings down two radicand bits and
// decides the next root bit.
module vec_isqrt_step
  import vec_pkg::*;
#(
  parameter int ROOT_W = root_width(VEC_WIDTH)
) (
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        bits_i,
  output logic [ROOT_W+1:0] rem_o,
  output logic [ROOT_W-1:0] root_o
);

  logic [ROOT_W+1:0] rem_sh;
  logic [ROOT_W+1:0] trial;
  logic              fits;

  // The partial remainder never exceeds 2*root, so the bits shifted out are zero.
  assign rem_sh = (rem_i << 2) | {{ROOT_W{1'b0}}, bits_i};
  assign trial  = {root_i, 2'b01};
  assign fits   = (rem_sh >= trial);
  assign rem_o  = fits ? (rem_sh - trial) : rem_sh;
  assign root_o = (root_i << 1) | {{(ROOT_W-1){1'b0}}, fits};

endmodule

// File: rtl/vec_isqrt.sv
// Multi-cycle integer square root, one root bit per clock, valid/ready on both sides.
// Define VEC_ISQRT_REM_EN to export the final remainder on out_rem.
module vec_isqrt
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
`ifdef VEC_ISQRT_REM_EN
  output logic [WIDTH/2:0]   out_rem,
`endif
  output logic               busy
);

  localparam int RW = root_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(RW - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $fatal(1, "vec_isqrt: WIDTH must be even and at least 4");
  end

  isqrt_state_e    state_q;
  logic [WIDTH-1:0] x_q;
  logic [RW+1:0]   rem_q;
  logic [RW-1:0]   root_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [RW+1:0]   rem_d;
  logic [RW-1:0]   root_d;
  logic            accept;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  vec_isqrt_step #(
    .ROOT_W (RW)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (x_q[WIDTH-1 -: 2]),
    .rem_o  (rem_d),
    .root_o (root_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= in_radicand;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          x_q    <= x_q << 2;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Retiring and accepting on the same edge goes straight back to CALC.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              x_q     <= in_radicand;
              rem_q   <= '0;
              root_q  <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_root  = root_q;
`ifdef VEC_ISQRT_REM_EN
  assign out_rem   = rem_q[RW:0];
`endif

endmodule

// File: tb/tb_vec_isqrt.sv
// Randomized and directed bench for vec_isqrt against an arithmetic square-root model.
// Build with and without VEC_ISQRT_REM_EN.
module tb_vec_isqrt;

  localparam int W  = 32;
  localparam int RW = W / 2;
  localparam int LAT = RW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_radicand;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_root;
`ifdef VEC_ISQRT_REM_EN
  logic [RW:0]   out_rem;
`endif
  logic          busy;

  vec_isqrt #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
`ifdef VEC_ISQRT_REM_EN
    .out_rem     (out_rem),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rand_or = 1'b0;

  typedef struct {
    logic [W-1:0] x;
    int           acc_cyc;
  } ent_t;
  ent_t q[$];

  logic [RW-1:0] ret_root[$];
  int            ret_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor(sqrt(x)) from real sqrt, corrected to the exact integer.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($rtoi($floor($sqrt(real'(x)))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Per-cycle scoreboard: queue of accepted operands with their accept edge.
  initial begin
    bit reset_pend, accept_pend, retire_pend, started, exp_valid, exp_ready, exp_busy;
    logic [W-1:0] acc_x;
    longint unsigned r, x;
    reset_pend = 0; accept_pend = 0; retire_pend = 0; started = 0; acc_x = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_pend) begin
        q.delete();
        started = 1;
      end else if (started) begin
        if (retire_pend) void'(q.pop_front());
        if (accept_pend) q.push_back('{x: acc_x, acc_cyc: cyc});
      end
      exp_valid = 0; exp_ready = 0;
      if (started) begin
        exp_valid = (q.size() > 0) && ((cyc - q[0].acc_cyc) >= LAT);
        exp_ready = (q.size() == 0) || (exp_valid && out_ready);
        exp_busy  = (q.size() > 0) && !exp_valid;
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (exp_valid) begin
          x = 64'(q[0].x);
          r = isqrt(x);
          chk("out_root", 64'(out_root), r);
`ifdef VEC_ISQRT_REM_EN
          chk("out_rem", 64'(out_rem), x - r * r);
          chk("identity", 64'(out_root) * 64'(out_root) + 64'(out_rem), x);
`endif
          if (out_ready) begin
            ret_root.push_back(out_root);
            ret_cyc.push_back(cyc);
          end
        end
      end
      reset_pend  = !rst_n;
      accept_pend = rst_n && started && in_valid && exp_ready;
      acc_x       = in_radicand;
      retire_pend = rst_n && exp_valid && out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send(input logic [W-1:0] x);
    int  n;
    logic ok;
    in_radicand = x;
    in_valid    = 1'b1;
    n = 0;
    forever begin
      #1;
      ok = in_ready;
      tick();
      n++;
      if (ok === 1'b1) break;
      if (n > 200) begin
        chk("accept_timeout", 64'(n), 64'(0));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) chk("result_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic expect_lit(input string name, input logic [RW-1:0] r, input logic [RW:0] rm);
    chk({name, "_root"}, 64'(out_root), 64'(r));
`ifdef VEC_ISQRT_REM_EN
    chk({name, "_rem"}, 64'(out_rem), 64'(rm));
`else
    if (rm != rm) chk({name, "_rem"}, 64'(0), 64'(1));
`endif
  endtask

  task automatic run_one(input string name, input logic [W-1:0] x,
                         input logic [RW-1:0] r, input logic [RW:0] rm);
    int n;
    out_ready = 1'b0;
    send(x);
    wait_valid(n);
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    expect_lit(name, r, rm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] x;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_radicand = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_root", 64'(out_root), 64'(0));
    chk("reset_ready", 64'(in_ready), 64'(1));
`ifdef VEC_ISQRT_REM_EN
    chk("reset_rem", 64'(out_rem), 64'(0));
`endif

    // Model pins against hand-computed roots.
    chk("model_25", isqrt(25), 64'd5);
    chk("model_1000", isqrt(1000), 64'd31);
    chk("model_max", isqrt(64'hFFFF_FFFF), 64'hFFFF);
    chk("model_50", isqrt(50), 64'd7);

    // Reset in the middle of a calculation discards it.
    send(32'h0000_0400);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_ready", 64'(in_ready), 64'(1));
    chk("midreset_valid", 64'(out_valid), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    repeat (20) tick();

    run_one("sq25", 32'd25, 16'd5, 17'd0);
    run_one("max", 32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE);
    run_one("zero", 32'd0, 16'd0, 17'd0);
    run_one("one", 32'd1, 16'd1, 17'd0);

    // Backpressure, and an operand offered during CALC must wait.
    out_ready = 1'b0;
    send(32'd1000);
    in_radicand = 32'd7;
    in_valid    = 1'b1;
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      expect_lit("bp_hold", 16'd31, 17'd39);
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_valid(n);
    expect_lit("bp_next", 16'd2, 17'd3);
    out_ready = 1'b1;
    tick();

    // Back-to-back with in_valid held high.
    ret_root.delete();
    ret_cyc.delete();
    out_ready = 1'b1;
    send(32'd49);
    send(32'd50);
    send(32'd81);
    repeat (20) tick();
    chk("b2b_count", 64'(ret_root.size()), 64'(3));
    if (ret_root.size() == 3) begin
      chk("b2b_root0", 64'(ret_root[0]), 64'd7);
      chk("b2b_root1", 64'(ret_root[1]), 64'd7);
      chk("b2b_root2", 64'(ret_root[2]), 64'd9);
      chk("b2b_gap0", 64'(ret_cyc[1] - ret_cyc[0]), 64'(LAT + 1));
      chk("b2b_gap1", 64'(ret_cyc[2] - ret_cyc[1]), 64'(LAT + 1));
    end

    // Random radicands with random consumer backpressure and idle gaps.
    rand_or = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 4))
        0: x = $urandom;
        1: begin k = $urandom_range(1, 65535); x = W'(k * k); end
        2: begin k = $urandom_range(1, 65535); x = W'(k * k - 1); end
        3: x = $urandom_range(0, 999);
        default: x = 32'hFFFF_FFFF - $urandom_range(0, 100);
      endcase
      repeat ($urandom_range(0, 2)) tick();
      send(x);
    end
    rand_or   = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
